// File: rtl/sfx_pkg.sv
// Shared types and constants for the sound-effect scheduler: FSM states,
// effect ids and the default note table of square-wave half-periods.
package sfx_pkg;

  localparam int SFX_N_REQ = 4;
  localparam int SFX_NOTES = 4;
  localparam int HP_W      = 17;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } sfx_state_e;

  localparam int JUMP    = 0;
  localparam int SQUASH  = 1;
  localparam int GOAL    = 2;
  localparam int TIMEOUT = 3;

  typedef logic [HP_W-1:0] half_period_t;

  // Row = effect id, column = note slot; a zero half-period ends the effect early.
  typedef half_period_t [0:SFX_N_REQ-1][0:SFX_NOTES-1] hp_table_t;

  localparam hp_table_t NOTE_HP = '{
    '{17'd14261, 17'd11304, 17'd9514,  17'd0},
    '{17'd25000, 17'd30000, 17'd0,     17'd0},
    '{17'd9514,  17'd7551,  17'd6356,  17'd4757},
    '{17'd28522, 17'd28522, 17'd28522, 17'd0}
  };

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sfx_tone_gen.sv
// Half-period divider: toggles the tone every halfPeriod cycles, giving a
// square wave of exactly 2*halfPeriod cycles. restart re-aligns it to a high phase.
module sfx_tone_gen
  import sfx_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         restart,
  input  half_period_t halfPeriod,
  output logic         tone
);

  half_period_t phase_q, phase_d;
  logic         tone_q, tone_d;

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
      tone_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      tone_q  <= tone_d;
    end
  end

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    phase_d = phase_q + 1'b1;
    tone_d  = tone_q;
    if (restart) begin
      phase_d = '0;
      tone_d  = 1'b1;
    end else if (phase_q == halfPeriod - 1'b1) begin
      phase_d = '0;
      tone_d  = ~tone_q;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/sfx_scheduler.sv
// Edge-detects effect requests, arbitrates by fixed priority with preemption,
// and sequences the winning effect's notes and gaps onto one tone output.
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int        N_REQ       = SFX_N_REQ,
  parameter int        NOTE_CYCLES = 3_125_000,
  parameter int        GAP_CYCLES  = 250_000,
  parameter int        NOTES       = SFX_NOTES,
  parameter hp_table_t HP_TABLE    = NOTE_HP
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         sfxReq,
  input  logic                     mute,
  output logic                     toneOut,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] activeId
);

  localparam int ID_W   = $clog2(N_REQ);
  localparam int NOTE_W = (NOTES > 1) ? $clog2(NOTES) : 1;
  localparam int DUR_W  = $clog2(max_int(max_int(NOTE_CYCLES, GAP_CYCLES), 2));

  sfx_state_e        state_q, state_d;
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic [N_REQ-1:0]  prev_req_q;
  logic [ID_W-1:0]   active_q, active_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [DUR_W-1:0]  dur_q, dur_d;

  logic [N_REQ-1:0]  rise;
  logic [N_REQ-1:0]  take_mask;
  logic              win_valid;
  logic [ID_W-1:0]   win_id;
  logic              start;
  logic              restart;
  half_period_t      cur_hp;
  half_period_t      next_hp;
  logic              tone;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      prev_req_q <= '0;
      active_q   <= '0;
      note_q     <= '0;
      dur_q      <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      prev_req_q <= sfxReq;
      active_q   <= active_d;
      note_q     <= note_d;
      dur_q      <= dur_d;
    end
  end

  assign rise = sfxReq & ~prev_req_q;

  // Ascending scan: the last set bit seen, i.e. the highest index, wins.
  always_comb begin
    win_valid = |pending_q;
    win_id    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pending_q[i]) win_id = ID_W'(i);
    end
  end

  assign cur_hp = HP_TABLE[active_q][note_q];

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    note_d   = note_q;
    dur_d    = dur_q + 1'b1;
    start    = 1'b0;
    restart  = 1'b0;
    next_hp  = '0;
    if (note_q != NOTE_W'(NOTES - 1)) next_hp = HP_TABLE[active_q][note_q + 1'b1];

    case (state_q)
      IDLE: begin
        dur_d = '0;
        if (win_valid) start = 1'b1;
      end
      PLAY: begin
        if (win_valid && (win_id > active_q)) begin
          start = 1'b1;
        end else if (dur_q == DUR_W'(NOTE_CYCLES - 1)) begin
          dur_d   = '0;
          state_d = (next_hp != '0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (win_valid && (win_id > active_q)) begin
          start = 1'b1;
        end else if (dur_q == DUR_W'(GAP_CYCLES - 1)) begin
          dur_d   = '0;
          state_d = PLAY;
          note_d  = note_q + 1'b1;
          restart = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh start (from idle or by preemption) always begins at note 0.
    if (start) begin
      state_d  = PLAY;
      active_d = win_id;
      note_d   = '0;
      dur_d    = '0;
      restart  = 1'b1;
    end

    take_mask = start ? (N_REQ'(1) << win_id) : '0;
    pending_d = (pending_q | rise) & ~take_mask;
  end

  sfx_tone_gen u_tone_gen (
    .clk        (clk),
    .reset      (reset),
    .restart    (restart),
    .halfPeriod (cur_hp),
    .tone       (tone)
  );

  assign busy     = (state_q != IDLE);
  assign activeId = active_q;
  assign toneOut  = tone & (state_q == PLAY) & ~mute & busy;

endmodule
